// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered RV32IM decode stage with handshake and MUL/DIV scoreboard
// Decoded fields are captured into one pipeline register; issue is gated by busy bits of outstanding long ops.
module decode_stage #(
   parameter int DATA_WIDTH        = 32,
   parameter int REGADDR_WIDTH     = 5,
   parameter int INSTRUCTION_WIDTH = 32,
   parameter int RESLT_SELCT_WIDTH = 3
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            instr_valid,
   input  logic [INSTRUCTION_WIDTH-1:0]    instr_in,
   output logic                            instr_ready,
   input  logic                            flush,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [REGADDR_WIDTH-1:0]        a_location,
   output logic [REGADDR_WIDTH-1:0]        b_location,
   output logic                            immediateSelect,
   output logic [DATA_WIDTH-1:0]           immediateVal,
   output logic                            unsignedSelect,
   output logic                            subtractEnable,
   output logic [1:0]                      logicOp,
   output logic [REGADDR_WIDTH-1:0]        writeSelect,
   output logic                            writeEnable,
   output logic [RESLT_SELCT_WIDTH-1:0]    resultSelect,
   output logic                            error,
   input  logic                            wb_valid,
   input  logic [REGADDR_WIDTH-1:0]        wb_addr,
   output logic [2**REGADDR_WIDTH-1:0]     busy_vector
);

   localparam int NUM_REGS = 2**REGADDR_WIDTH;

   localparam logic [6:0] OPC_OP_IMM = 7'h13;
   localparam logic [6:0] OPC_OP     = 7'h33;

   localparam logic [RESLT_SELCT_WIDTH-1:0] SEL_ADD   = RESLT_SELCT_WIDTH'(0);
   localparam logic [RESLT_SELCT_WIDTH-1:0] SEL_MUL   = RESLT_SELCT_WIDTH'(1);
   localparam logic [RESLT_SELCT_WIDTH-1:0] SEL_DIV   = RESLT_SELCT_WIDTH'(2);
   localparam logic [RESLT_SELCT_WIDTH-1:0] SEL_REM   = RESLT_SELCT_WIDTH'(3);
   localparam logic [RESLT_SELCT_WIDTH-1:0] SEL_LOGIC = RESLT_SELCT_WIDTH'(4);
   localparam logic [RESLT_SELCT_WIDTH-1:0] SEL_SLT   = RESLT_SELCT_WIDTH'(5);

   localparam logic [1:0] LOP_AND = 2'd0;
   localparam logic [1:0] LOP_OR  = 2'd1;
   localparam logic [1:0] LOP_XOR = 2'd2;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic [4:0] rd_f;
   logic [4:0] rs1_f;
   logic [4:0] rs2_f;

   assign opcode = instr_in[6:0];
   assign rd_f   = instr_in[11:7];
   assign funct3 = instr_in[14:12];
   assign rs1_f  = instr_in[19:15];
   assign rs2_f  = instr_in[24:20];
   assign funct7 = instr_in[31:25];

   logic                         d_sup;
   logic                         d_imm;
   logic                         d_uns;
   logic                         d_sub;
   logic [1:0]                   d_lop;
   logic [RESLT_SELCT_WIDTH-1:0] d_rsel;
   logic                         alu_basic;

   // OP-IMM and OP with funct7=0 share one funct3 table for ADD/SLT/SLTU/logic.
   assign alu_basic = (opcode == OPC_OP_IMM) || ((opcode == OPC_OP) && (funct7 == 7'h00));

   always_comb begin
      d_sup  = 1'b0;
      d_imm  = (opcode == OPC_OP_IMM);
      d_uns  = 1'b0;
      d_sub  = 1'b0;
      d_lop  = LOP_AND;
      d_rsel = SEL_ADD;
      if (alu_basic) begin
         case (funct3)
            3'd0: d_sup = 1'b1;
            3'd2: begin d_sup = 1'b1; d_rsel = SEL_SLT; end
            3'd3: begin d_sup = 1'b1; d_rsel = SEL_SLT; d_uns = 1'b1; end
            3'd4: begin d_sup = 1'b1; d_rsel = SEL_LOGIC; d_lop = LOP_XOR; end
            3'd6: begin d_sup = 1'b1; d_rsel = SEL_LOGIC; d_lop = LOP_OR; end
            3'd7: begin d_sup = 1'b1; d_rsel = SEL_LOGIC; d_lop = LOP_AND; end
            default: d_sup = 1'b0;
         endcase
      end else if ((opcode == OPC_OP) && (funct7 == 7'h20)) begin
         if (funct3 == 3'd0) begin
            d_sup = 1'b1;
            d_sub = 1'b1;
         end
      end else if ((opcode == OPC_OP) && (funct7 == 7'h01)) begin
         case (funct3)
            3'd0: begin d_sup = 1'b1; d_rsel = SEL_MUL; end
            3'd4: begin d_sup = 1'b1; d_rsel = SEL_DIV; end
            3'd5: begin d_sup = 1'b1; d_rsel = SEL_DIV; d_uns = 1'b1; end
            3'd6: begin d_sup = 1'b1; d_rsel = SEL_REM; end
            3'd7: begin d_sup = 1'b1; d_rsel = SEL_REM; d_uns = 1'b1; end
            default: d_sup = 1'b0;
         endcase
      end
   end

   logic                held;
   logic [NUM_REGS-1:0] busy;
   logic                hazard;
   logic                fire;
   logic                capture;
   logic [NUM_REGS-1:0] set_mask;
   logic [NUM_REGS-1:0] clr_mask;

   assign busy_vector = busy;

   // Error words carry zeroed register fields, but they must bypass the stall regardless.
   assign hazard = !error &&
                   (busy[a_location] ||
                    (!immediateSelect && busy[b_location]) ||
                    (writeEnable && busy[writeSelect]));

   assign out_valid   = held && !hazard;
   assign fire        = out_valid && out_ready;
   assign instr_ready = !held || fire;
   assign capture     = instr_valid && instr_ready && !flush;

   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (fire && writeEnable &&
          ((resultSelect == SEL_MUL) || (resultSelect == SEL_DIV) || (resultSelect == SEL_REM)))
         set_mask[writeSelect] = 1'b1;
      if (wb_valid)
         clr_mask[wb_addr] = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         held <= 1'b0;
         busy <= '0;
      end else begin
         // Set is applied after clear so a same-register collision leaves the bit set.
         busy <= ((busy & ~clr_mask) | set_mask) & {{(NUM_REGS-1){1'b1}}, 1'b0};
         if (flush)
            held <= 1'b0;
         else if (capture)
            held <= 1'b1;
         else if (fire)
            held <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_location      <= '0;
         b_location      <= '0;
         immediateSelect <= 1'b0;
         immediateVal    <= '0;
         unsignedSelect  <= 1'b0;
         subtractEnable  <= 1'b0;
         logicOp         <= 2'd0;
         writeSelect     <= '0;
         writeEnable     <= 1'b0;
         resultSelect    <= '0;
         error           <= 1'b0;
      end else if (capture) begin
         a_location      <= d_sup ? REGADDR_WIDTH'(rs1_f) : '0;
         b_location      <= d_sup ? REGADDR_WIDTH'(rs2_f) : '0;
         immediateSelect <= d_sup && d_imm;
         immediateVal    <= d_sup ? {{(DATA_WIDTH-12){instr_in[31]}}, instr_in[31:20]} : '0;
         unsignedSelect  <= d_sup && d_uns;
         subtractEnable  <= d_sup && d_sub;
         logicOp         <= d_sup ? d_lop : 2'd0;
         writeSelect     <= d_sup ? REGADDR_WIDTH'(rd_f) : '0;
         writeEnable     <= d_sup && (rd_f != 5'd0);
         resultSelect    <= d_sup ? d_rsel : SEL_ADD;
         error           <= !d_sup;
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - randomized bench for decode_stage against a mnemonic-level reference model
// Directed RV32IM scenarios pin the model; a random phase checks every cycle.
module tb_decode_stage;

   localparam int DW = 32;
   localparam int RW = 5;
   localparam int IW = 32;
   localparam int SW = 3;

   logic            clk = 1'b0;
   logic            reset;
   logic            instr_valid;
   logic [IW-1:0]   instr_in;
   logic            instr_ready;
   logic            flush;
   logic            out_valid;
   logic            out_ready;
   logic [RW-1:0]   a_location;
   logic [RW-1:0]   b_location;
   logic            immediateSelect;
   logic [DW-1:0]   immediateVal;
   logic            unsignedSelect;
   logic            subtractEnable;
   logic [1:0]      logicOp;
   logic [RW-1:0]   writeSelect;
   logic            writeEnable;
   logic [SW-1:0]   resultSelect;
   logic            error;
   logic            wb_valid;
   logic [RW-1:0]   wb_addr;
   logic [2**RW-1:0] busy_vector;

   decode_stage #(.DATA_WIDTH(DW), .REGADDR_WIDTH(RW), .INSTRUCTION_WIDTH(IW), .RESLT_SELCT_WIDTH(SW)) dut (
      .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_in(instr_in),
      .instr_ready(instr_ready), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .a_location(a_location), .b_location(b_location), .immediateSelect(immediateSelect),
      .immediateVal(immediateVal), .unsignedSelect(unsignedSelect), .subtractEnable(subtractEnable),
      .logicOp(logicOp), .writeSelect(writeSelect), .writeEnable(writeEnable),
      .resultSelect(resultSelect), .error(error), .wb_valid(wb_valid), .wb_addr(wb_addr),
      .busy_vector(busy_vector)
   );

   always #5 clk = ~clk;

   typedef enum {M_NONE, M_ADD, M_SUB, M_SLT, M_SLTU, M_AND, M_OR, M_XOR,
                 M_MUL, M_DIV, M_DIVU, M_REM, M_REMU} mn_t;

   typedef struct {
      bit          err;
      bit          imm;
      bit          uns;
      bit          sub;
      int          lop;
      int          rsel;
      int          a;
      int          b;
      int          wsel;
      bit          we;
      logic [31:0] immv;
   } exp_t;

   int n_cmp = 0;
   int n_bad = 0;

   bit          m_held;
   logic [31:0] m_instr;
   logic [31:0] m_busy;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t ref_decode(input logic [31:0] i);
      exp_t e;
      mn_t  m;
      bit   is_imm;
      int   opc, f3, f7;
      opc = int'(i[6:0]);
      f3  = int'(i[14:12]);
      f7  = int'(i[31:25]);
      is_imm = (opc == 'h13);
      m = M_NONE;
      if (opc == 'h13 || (opc == 'h33 && f7 == 0)) begin
         case (f3)
            0: m = M_ADD;
            2: m = M_SLT;
            3: m = M_SLTU;
            4: m = M_XOR;
            6: m = M_OR;
            7: m = M_AND;
            default: m = M_NONE;
         endcase
      end else if (opc == 'h33 && f7 == 'h20 && f3 == 0) begin
         m = M_SUB;
      end else if (opc == 'h33 && f7 == 1) begin
         case (f3)
            0: m = M_MUL;
            4: m = M_DIV;
            5: m = M_DIVU;
            6: m = M_REM;
            7: m = M_REMU;
            default: m = M_NONE;
         endcase
      end
      e.err = (m == M_NONE);
      e.imm = !e.err && is_imm;
      e.uns = (m == M_SLTU) || (m == M_DIVU) || (m == M_REMU);
      e.sub = (m == M_SUB);
      e.lop = (m == M_OR) ? 1 : (m == M_XOR) ? 2 : 0;
      case (m)
         M_MUL:               e.rsel = 1;
         M_DIV, M_DIVU:       e.rsel = 2;
         M_REM, M_REMU:       e.rsel = 3;
         M_AND, M_OR, M_XOR:  e.rsel = 4;
         M_SLT, M_SLTU:       e.rsel = 5;
         default:             e.rsel = 0;
      endcase
      e.a    = e.err ? 0 : int'(i[19:15]);
      e.b    = e.err ? 0 : int'(i[24:20]);
      e.wsel = e.err ? 0 : int'(i[11:7]);
      e.we   = !e.err && (i[11:7] != 0);
      e.immv = e.err ? 32'h0 : {{20{i[31]}}, i[31:20]};
      return e;
   endfunction

   function automatic bit model_hazard(input exp_t e);
      if (e.err) return 1'b0;
      return m_busy[e.a] || (!e.imm && m_busy[e.b]) || (e.we && m_busy[e.wsel]);
   endfunction

   task automatic model_reset();
      m_held  = 1'b0;
      m_instr = 32'h0;
      m_busy  = 32'h0;
   endtask

   task automatic settle();
      exp_t e;
      bit   ov;
      #1;
      e  = ref_decode(m_instr);
      ov = m_held && !model_hazard(e);
      chk("out_valid", out_valid, ov);
      chk("instr_ready", instr_ready, !m_held || (ov && out_ready));
      chk("busy_vector", busy_vector, m_busy);
      if (m_held) begin
         chk("error", error, e.err);
         chk("a_location", a_location, e.a);
         chk("b_location", b_location, e.b);
         chk("immediateSelect", immediateSelect, e.imm);
         chk("immediateVal", immediateVal, e.immv);
         chk("unsignedSelect", unsignedSelect, e.uns);
         chk("subtractEnable", subtractEnable, e.sub);
         chk("logicOp", logicOp, e.lop);
         chk("writeSelect", writeSelect, e.wsel);
         chk("writeEnable", writeEnable, e.we);
         chk("resultSelect", resultSelect, e.rsel);
      end
   endtask

   task automatic model_update();
      exp_t e;
      bit   ov, fire, ir, cap;
      e    = ref_decode(m_instr);
      ov   = m_held && !model_hazard(e);
      fire = ov && out_ready;
      ir   = !m_held || fire;
      cap  = instr_valid && ir;
      if (wb_valid) m_busy[wb_addr] = 1'b0;
      if (fire && e.we && e.rsel >= 1 && e.rsel <= 3) m_busy[e.wsel] = 1'b1;
      m_busy[0] = 1'b0;
      if (flush) m_held = 1'b0;
      else if (cap) begin
         m_held  = 1'b1;
         m_instr = instr_in;
      end else if (fire) m_held = 1'b0;
   endtask

   task automatic advance();
      @(posedge clk);
      if (reset) model_reset();
      else model_update();
      @(negedge clk);
   endtask

   function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
      return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
   endfunction

   function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd);
      return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), 7'h13};
   endfunction

   function automatic logic [31:0] rnd_instr();
      int k;
      k = $urandom_range(0, 15);
      if (k == 0) return $urandom;
      if (k < 6)
         return enc_i($urandom_range(0, 4095), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      if (k < 11)
         return enc_r((k == 6) ? 'h20 : 0, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      return enc_r(1, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
   endfunction

   task automatic idle_inputs();
      instr_valid = 1'b0;
      instr_in    = 32'h0;
      flush       = 1'b0;
      out_ready   = 1'b1;
      wb_valid    = 1'b0;
      wb_addr     = '0;
   endtask

   logic [31:0] q[$];
   logic [31:0] got[$];

   initial begin
      reset = 1'b1;
      idle_inputs();
      out_ready = 1'b0;
      model_reset();

      // Reset state
      @(negedge clk);
      settle();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_instr_ready", instr_ready, 1);
      chk("rst_busy", busy_vector, 0);
      chk("rst_immediateVal", immediateVal, 0);
      chk("rst_resultSelect", resultSelect, 0);
      chk("rst_writeEnable", writeEnable, 0);
      chk("rst_error", error, 0);
      reset = 1'b0;
      advance();

      // Encoding check
      instr_valid = 1'b1; instr_in = 32'h00500093; out_ready = 1'b0;
      settle(); advance();
      instr_in = 32'hFFF00093; out_ready = 1'b1;
      settle();
      chk("addi_out_valid", out_valid, 1);
      chk("addi_resultSelect", resultSelect, 0);
      chk("addi_immSel", immediateSelect, 1);
      chk("addi_immVal", immediateVal, 32'h5);
      chk("addi_writeSelect", writeSelect, 1);
      chk("addi_writeEnable", writeEnable, 1);
      advance();
      instr_valid = 1'b0;
      settle();
      chk("addi_neg_immVal", immediateVal, 32'hFFFFFFFF);
      advance();

      // Backpressure: 4 ADDIs, execute stalls for 3 cycles
      for (int k = 1; k <= 4; k++) q.push_back(enc_i(k, 0, 0, k));
      for (int c = 0; c < 30 && got.size() < 4; c++) begin
         instr_valid = (q.size() > 0);
         instr_in    = (q.size() > 0) ? q[0] : 32'h0;
         out_ready   = !(c >= 1 && c <= 3);
         settle();
         if (c >= 1 && c <= 3) begin
            chk("bp_instr_ready", instr_ready, 0);
            chk("bp_stable_imm", immediateVal, 1);
         end
         if (out_valid && out_ready) got.push_back(immediateVal);
         if (instr_valid && instr_ready) void'(q.pop_front());
         advance();
      end
      chk("bp_issue_count", got.size(), 4);
      for (int k = 0; k < 4; k++)
         if (k < got.size()) chk("bp_issue_order", got[k], k + 1);
      idle_inputs();

      // RAW stall on MUL result
      instr_valid = 1'b1; instr_in = 32'h022081B3;
      settle(); advance();
      instr_in = 32'h00118233;
      settle(); advance();
      instr_valid = 1'b0;
      for (int c = 0; c < 5; c++) begin
         settle();
         chk("raw_busy3", busy_vector[3], 1);
         chk("raw_stalled", out_valid, 0);
         advance();
      end
      wb_valid = 1'b1; wb_addr = 5'd3;
      settle();
      chk("raw_same_cycle_clear", out_valid, 0);
      advance();
      wb_valid = 1'b0;
      settle();
      chk("raw_released", out_valid, 1);
      advance();

      // Squash cases
      instr_valid = 1'b1; instr_in = enc_r(1, 3, 2, 0, 1);
      settle(); advance();
      instr_in = 32'h0000807F;
      settle(); advance();
      instr_in = enc_r(0, 2, 1, 0, 0);
      settle();
      chk("sq_busy1", busy_vector[1], 1);
      chk("sq_err_issues", out_valid, 1);
      chk("sq_err_flag", error, 1);
      chk("sq_err_we", writeEnable, 0);
      advance();
      instr_valid = 1'b0; wb_valid = 1'b1; wb_addr = 5'd1;
      settle();
      chk("sq_x0_we", writeEnable, 0);
      advance();
      wb_valid = 1'b0;
      instr_valid = 1'b1; instr_in = enc_r(1, 2, 1, 0, 0);
      settle(); advance();
      instr_valid = 1'b0;
      settle();
      chk("sq_mul_x0_valid", out_valid, 1);
      advance();
      settle();
      chk("sq_mul_x0_nobusy", busy_vector, 0);
      advance();

      // Set/clear collision, then flush
      instr_valid = 1'b1; instr_in = enc_r(1, 2, 1, 0, 5);
      settle(); advance();
      instr_valid = 1'b0; wb_valid = 1'b1; wb_addr = 5'd5;
      settle(); advance();
      wb_valid = 1'b0;
      settle();
      chk("coll_set_wins", busy_vector[5], 1);
      advance();
      flush = 1'b1; instr_valid = 1'b1; instr_in = enc_i(7, 0, 0, 1);
      settle(); advance();
      flush = 1'b0; instr_valid = 1'b0; wb_valid = 1'b1; wb_addr = 5'd5;
      settle();
      chk("flush_dropped", out_valid, 0);
      chk("flush_ready", instr_ready, 1);
      chk("flush_keeps_busy", busy_vector[5], 1);
      advance();
      wb_valid = 1'b0;

      // Reset while stalled
      instr_valid = 1'b1; instr_in = 32'h022081B3;
      settle(); advance();
      instr_in = 32'h00118233;
      settle(); advance();
      instr_valid = 1'b0;
      settle();
      chk("rs_pre_stalled", out_valid, 0);
      reset = 1'b1;
      #1;
      chk("rs_out_valid", out_valid, 0);
      chk("rs_busy", busy_vector, 0);
      chk("rs_instr_ready", instr_ready, 1);
      model_reset();
      advance();
      reset = 1'b0;
      settle(); advance();

      // Random phase
      for (int c = 0; c < 3000; c++) begin
         instr_valid = ($urandom_range(0, 2) != 0);
         instr_in    = rnd_instr();
         out_ready   = ($urandom_range(0, 3) != 0);
         wb_valid    = ($urandom_range(0, 2) == 0);
         wb_addr     = 5'($urandom_range(0, 7));
         flush       = ($urandom_range(0, 24) == 0);
         settle();
         advance();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
